nbit_pts_shiftreg: RTL and testbench

Parallel-in, serial-out shift register with a valid/ready handshake on both sides. It is the transmitting counterpart of the team's serial-in shift registers, such as the branch-history shift register. A parallel word is loaded once, then emitted one bit per accepted transfer. Default bit order is MSB-first, so a downstream serial-in register that shifts in at its LSB reconstructs the original word unchanged.

---
 rtl/nbit_pts_shiftreg.sv | 61 ++++++
 tb/tb_nbit_pts_shiftreg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nbit_pts_shiftreg.sv
// Parallel-in, serial-out shift register with valid/ready on the load and serial sides.
// A loaded word is emitted one bit per accepted transfer, MSB-first by default.
module nbit_pts_shiftreg #(
    parameter int size      = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            flush,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [size-1:0] load_data,
    output logic            ser_valid,
    input  logic            ser_ready,
    output logic            ser_out,
    output logic            ser_last,
    output logic            busy
);

    // Handshakes: a transfer happens on a rising CLK edge where valid && ready are both 1;
    // valid and its payload stay stable until accepted, and ready never waits on a transfer.
    localparam int CW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [size-1:0]   shreg;
    logic [CW-1:0]     count;

    assign busy       = (state == SHIFT);
    assign ser_valid  = (state == SHIFT);
    assign ser_last   = (state == SHIFT) && (count == '0);
    assign ser_out    = MSB_FIRST ? shreg[size-1] : shreg[0];
    // The final transfer frees the register, so a new word may enter with no bubble.
    assign load_ready = (state == IDLE) || (ser_last && ser_ready);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
        end else if (flush) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
        end else if (load_valid && load_ready) begin
            state <= SHIFT;
            shreg <= load_data;
            count <= CW'(size - 1);
        end else if ((state == SHIFT) && ser_ready) begin
            if (count == '0) begin
                state <= IDLE;
                shreg <= '0;
            end else begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nbit_pts_shiftreg.sv
// Directed bench for nbit_pts_shiftreg: MSB-first, LSB-first and size=1 instances
// checked against hand-computed bit streams.
module tb_nbit_pts_shiftreg;

    logic CLK;
    logic nRST;

    logic       flush, load_valid, load_ready, ser_valid, ser_ready, ser_out, ser_last, busy;
    logic [2:0] load_data;
    logic       flush_l, load_valid_l, load_ready_l, ser_valid_l, ser_ready_l, ser_out_l, ser_last_l, busy_l;
    logic [2:0] load_data_l;
    logic       flush_1, load_valid_1, load_ready_1, ser_valid_1, ser_ready_1, ser_out_1, ser_last_1, busy_1;
    logic [0:0] load_data_1;

    logic [2:0] rx, rx_l;

    int n_vec;
    int n_err;

    nbit_pts_shiftreg #(.size(3), .MSB_FIRST(1'b1)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .ser_out(ser_out), .ser_last(ser_last), .busy(busy)
    );

    nbit_pts_shiftreg #(.size(3), .MSB_FIRST(1'b0)) dut_l (
        .CLK(CLK), .nRST(nRST), .flush(flush_l), .load_valid(load_valid_l),
        .load_ready(load_ready_l), .load_data(load_data_l), .ser_valid(ser_valid_l),
        .ser_ready(ser_ready_l), .ser_out(ser_out_l), .ser_last(ser_last_l), .busy(busy_l)
    );

    nbit_pts_shiftreg #(.size(1), .MSB_FIRST(1'b1)) dut1 (
        .CLK(CLK), .nRST(nRST), .flush(flush_1), .load_valid(load_valid_1),
        .load_ready(load_ready_1), .load_data(load_data_1), .ser_valid(ser_valid_1),
        .ser_ready(ser_ready_1), .ser_out(ser_out_1), .ser_last(ser_last_1), .busy(busy_1)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serial-in receivers that shift in at the LSB
    always @(posedge CLK) begin
        if (ser_valid && ser_ready)     rx   <= {rx[1:0], ser_out};
        if (ser_valid_l && ser_ready_l) rx_l <= {rx_l[1:0], ser_out_l};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ser(input string tag, input logic o, input logic l);
        check({tag, "_out"},   {31'd0, ser_out},   {31'd0, o});
        check({tag, "_last"},  {31'd0, ser_last},  {31'd0, l});
        check({tag, "_valid"}, {31'd0, ser_valid}, 32'd1);
        check({tag, "_busy"},  {31'd0, busy},      32'd1);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_valid"}, {31'd0, ser_valid},  32'd0);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
        check({tag, "_out"},   {31'd0, ser_out},    32'd0);
        check({tag, "_last"},  {31'd0, ser_last},   32'd0);
        check({tag, "_lrdy"},  {31'd0, load_ready}, 32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nRST = 1'b1;
        {flush, load_valid, ser_ready, load_data} = '0;
        {flush_l, load_valid_l, ser_ready_l, load_data_l} = '0;
        {flush_1, load_valid_1, ser_ready_1, load_data_1} = '0;
        #1 nRST = 1'b0;
        #1;
        chk_idle("rst");
        check("rst_lrdy_l", {31'd0, load_ready_l}, 32'd1);
        check("rst_lrdy_1", {31'd0, load_ready_1}, 32'd1);
        check("rst_valid_1", {31'd0, ser_valid_1}, 32'd0);
        #1 nRST = 1'b1;

        // Basic MSB-first: 101 -> 1,0,1
        load_data = 3'b101; load_valid = 1'b1; ser_ready = 1'b1;
        cyc(); load_valid = 1'b0; #1;
        chk_ser("basic_b0", 1'b1, 1'b0);
        cyc(); chk_ser("basic_b1", 1'b0, 1'b0);
        cyc(); chk_ser("basic_b2", 1'b1, 1'b1);
        check("basic_lrdy_last", {31'd0, load_ready}, 32'd1);
        cyc(); chk_idle("basic_end");

        // Loopback MSB-first: 110 reconstructed
        load_data = 3'b110; load_valid = 1'b1;
        cyc(); load_valid = 1'b0; #1;
        chk_ser("loop_b0", 1'b1, 1'b0);
        cyc(); chk_ser("loop_b1", 1'b1, 1'b0);
        cyc(); chk_ser("loop_b2", 1'b0, 1'b1);
        cyc(); check("loop_rx", {29'd0, rx}, 32'h6);

        // Loopback LSB-first: 011 -> 1,1,0
        load_data_l = 3'b011; load_valid_l = 1'b1; ser_ready_l = 1'b1;
        cyc(); load_valid_l = 1'b0; #1;
        check("lsb_b0", {30'd0, ser_out_l, ser_last_l}, 32'h2);
        cyc(); check("lsb_b1", {30'd0, ser_out_l, ser_last_l}, 32'h2);
        cyc(); check("lsb_b2", {30'd0, ser_out_l, ser_last_l}, 32'h1);
        cyc(); check("lsb_rx", {29'd0, rx_l}, 32'h6);
        check("lsb_idle", {31'd0, busy_l}, 32'd0);

        // Back-pressure: 100, stall 4 cycles on the first bit
        load_data = 3'b100; load_valid = 1'b1;
        cyc(); load_valid = 1'b0; ser_ready = 1'b0; #1;
        chk_ser("bp_b0", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_ser($sformatf("bp_hold%0d", i), 1'b1, 1'b0);
            check($sformatf("bp_lrdy%0d", i), {31'd0, load_ready}, 32'd0);
        end
        ser_ready = 1'b1;
        cyc(); chk_ser("bp_b1", 1'b0, 1'b0);
        cyc(); chk_ser("bp_b2", 1'b0, 1'b1);
        cyc(); chk_idle("bp_end");

        // Back-to-back: 111 then 010 held by the requester until accepted
        load_data = 3'b111; load_valid = 1'b1;
        cyc(); load_data = 3'b010; #1;
        chk_ser("b2b_b0", 1'b1, 1'b0);
        check("b2b_lrdy0", {31'd0, load_ready}, 32'd0);
        cyc(); chk_ser("b2b_b1", 1'b1, 1'b0);
        check("b2b_lrdy1", {31'd0, load_ready}, 32'd0);
        cyc(); chk_ser("b2b_b2", 1'b1, 1'b1);
        check("b2b_lrdy2", {31'd0, load_ready}, 32'd1);
        cyc(); load_valid = 1'b0; #1;
        chk_ser("b2b_b3", 1'b0, 1'b0);
        cyc(); chk_ser("b2b_b4", 1'b1, 1'b0);
        cyc(); chk_ser("b2b_b5", 1'b0, 1'b1);
        cyc(); chk_idle("b2b_end");

        // Flush mid-word with a competing load
        load_data = 3'b101; load_valid = 1'b1;
        cyc(); load_valid = 1'b0; #1;
        chk_ser("fl_b0", 1'b1, 1'b0);
        flush = 1'b1; load_valid = 1'b1; load_data = 3'b011;
        cyc(); flush = 1'b0; load_valid = 1'b0; #1;
        chk_idle("fl_after");
        cyc(); chk_idle("fl_after2");

        // Asynchronous reset mid-word
        load_data = 3'b101; load_valid = 1'b1;
        cyc(); load_valid = 1'b0; #1;
        chk_ser("ar_b0", 1'b1, 1'b0);
        #1 nRST = 1'b0;
        #1 chk_idle("ar_now");
        #1 nRST = 1'b1;
        cyc(); chk_idle("ar_after");

        // size=1: 1 then 0 streamed back-to-back
        load_data_1 = 1'b1; load_valid_1 = 1'b1; ser_ready_1 = 1'b1;
        cyc(); load_data_1 = 1'b0; #1;
        check("s1_b0", {29'd0, ser_valid_1, ser_out_1, ser_last_1}, 32'h7);
        check("s1_lrdy0", {31'd0, load_ready_1}, 32'd1);
        cyc(); load_valid_1 = 1'b0; #1;
        check("s1_b1", {29'd0, ser_valid_1, ser_out_1, ser_last_1}, 32'h5);
        cyc(); check("s1_end", {30'd0, ser_valid_1, busy_1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
